// File: rtl/seq_gen_pkg.sv
// Shared constants and value rules for the button-driven sequence generator.
// Helpers work on a 32-bit word and are masked down to the caller's DATA_WIDTH.
package seq_gen_pkg;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_GRAY = 2'd2;
  localparam logic [1:0] MODE_LFSR = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam int unsigned MAX_W = 32;
  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t width_mask(input int unsigned width);
    if (width >= MAX_W) return '1;
    return (word_t'(1) << width) - word_t'(1);
  endfunction

  function automatic word_t start_value(input logic [1:0] mode,
                                        input int unsigned width,
                                        input word_t seed);
    case (mode)
      MODE_DOWN: return width_mask(width);
      MODE_LFSR: return seed & width_mask(width);
      default:   return '0;
    endcase
  endfunction

  // GRAY advances the binary core; the Gray mapping is applied at the output.
  function automatic word_t next_value(input logic [1:0] mode,
                                       input word_t core,
                                       input int unsigned width,
                                       input word_t taps,
                                       input word_t seed);
    word_t m;
    word_t r;
    m = width_mask(width);
    case (mode)
      MODE_DOWN: r = (core - word_t'(1)) & m;
      MODE_LFSR: begin
        r = core[0] ? ((core >> 1) ^ taps) : (core >> 1);
        r = r & m;
        if (r == '0) r = seed & m;
      end
      default:   r = (core + word_t'(1)) & m;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_gen_ctrl_rate_div.sv
// CE tick divider: pulses step on the (rate+1)th ce after the last clear.
module seq_rate_div #(
  parameter int unsigned RATE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic                  clear,
  output logic                  step
);

  logic [RATE_WIDTH-1:0] tick_cnt;

  // rate is compared live so a new divisor takes effect immediately
  assign step = ce && (tick_cnt == rate);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (clear) begin
      tick_cnt <= '0;
    end else if (ce) begin
      tick_cnt <= (tick_cnt == rate) ? '0 : tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_gen_ctrl.sv
// Sequence generator core: IDLE/RUN/PAUSE control over four sequence modes,
// driven by one-cycle button pulses; DATA_WIDTH up to 32.
module seq_gen_ctrl
  import seq_gen_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 8'hB8,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = 8'h01,
  parameter int unsigned           RATE_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BTN_RUN,
  input  logic                  BTN_STEP,
  input  logic                  BTN_MODE,
  input  logic                  BTN_CLR,
  input  logic                  CE,
  input  logic [RATE_WIDTH-1:0] RATE,
  output logic [DATA_WIDTH-1:0] SEQ_OUT,
  output logic                  SEQ_STB,
  output logic [1:0]            MODE,
  output logic                  RUNNING
);

  logic [1:0]            state_q, state_n;
  logic [1:0]            mode_n, mode_inc;
  logic [DATA_WIDTH-1:0] core_q, core_n;
  logic [DATA_WIDTH-1:0] adv_val, start_cur, start_inc, seq_n;
  logic                  load, enter_run, run_ce, tick;

  assign mode_inc  = 2'(MODE + 2'd1);
  assign adv_val   = DATA_WIDTH'(next_value(MODE, word_t'(core_q), DATA_WIDTH,
                                            word_t'(LFSR_TAPS), word_t'(LFSR_SEED)));
  assign start_cur = DATA_WIDTH'(start_value(MODE, DATA_WIDTH, word_t'(LFSR_SEED)));
  assign start_inc = DATA_WIDTH'(start_value(mode_inc, DATA_WIDTH, word_t'(LFSR_SEED)));
  assign run_ce    = CE && (state_q == ST_RUN);

  seq_rate_div #(
    .RATE_WIDTH(RATE_WIDTH)
  ) u_rate_div (
    .clk  (CLK),
    .rst  (RST),
    .ce   (run_ce),
    .rate (RATE),
    .clear(enter_run),
    .step (tick)
  );

  // Button priority CLR > RUN > STEP > MODE; auto-step only when no button acts.
  always_comb begin
    state_n   = state_q;
    mode_n    = MODE;
    core_n    = core_q;
    load      = 1'b0;
    enter_run = 1'b0;
    if (BTN_CLR) begin
      state_n = ST_IDLE;
      core_n  = start_cur;
      load    = 1'b1;
    end else if (BTN_RUN) begin
      if (state_q == ST_RUN) begin
        state_n = ST_PAUSE;
      end else begin
        state_n   = ST_RUN;
        enter_run = 1'b1;
      end
    end else if (BTN_STEP && state_q != ST_RUN) begin
      state_n = ST_PAUSE;
      core_n  = adv_val;
      load    = 1'b1;
    end else if (BTN_MODE && state_q != ST_RUN) begin
      mode_n = mode_inc;
      core_n = start_inc;
      load   = 1'b1;
    end else if (state_q == ST_RUN && tick) begin
      core_n = adv_val;
      load   = 1'b1;
    end
  end

  assign seq_n = (mode_n == MODE_GRAY) ? (core_n ^ (core_n >> 1)) : core_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      MODE    <= MODE_UP;
      core_q  <= '0;
      SEQ_OUT <= '0;
      SEQ_STB <= 1'b0;
      RUNNING <= 1'b0;
    end else begin
      state_q <= state_n;
      MODE    <= mode_n;
      core_q  <= core_n;
      SEQ_STB <= load;
      RUNNING <= (state_n == ST_RUN);
      if (load) SEQ_OUT <= seq_n;
    end
  end

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Self-checking bench for seq_gen_ctrl: cycle model compared every cycle,
// plus directed button/CE scenarios with literal expectations.
module tb_seq_gen_ctrl;

  localparam int TAPS = 'hB8;
  localparam int SEED = 'h01;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_RUN = 1'b0, BTN_STEP = 1'b0, BTN_MODE = 1'b0, BTN_CLR = 1'b0;
  logic       CE = 1'b0;
  logic [3:0] RATE = 4'd0;
  logic [7:0] SEQ_OUT;
  logic       SEQ_STB;
  logic [1:0] MODE;
  logic       RUNNING;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // model: state 0 idle, 1 run, 2 pause; v is the binary core value
  int m_st = 0, m_mode = 0, m_v = 0, m_tick = 0;
  int exp_out = 0, exp_stb = 0, exp_mode = 0, exp_run = 0;

  seq_gen_ctrl #(
    .DATA_WIDTH(8), .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01), .RATE_WIDTH(4)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN_RUN(BTN_RUN), .BTN_STEP(BTN_STEP),
    .BTN_MODE(BTN_MODE), .BTN_CLR(BTN_CLR), .CE(CE), .RATE(RATE),
    .SEQ_OUT(SEQ_OUT), .SEQ_STB(SEQ_STB), .MODE(MODE), .RUNNING(RUNNING)
  );

  always #5 CLK = ~CLK;

  function automatic int m_start(input int mode);
    if (mode == 1) return 255;
    if (mode == 3) return SEED;
    return 0;
  endfunction

  function automatic int m_adv(input int mode, input int v);
    int r;
    case (mode)
      1: r = (v + 255) % 256;
      3: begin
        r = (v % 2 == 1) ? ((v / 2) ^ TAPS) : (v / 2);
        if (r == 0) r = SEED;
      end
      default: r = (v + 1) % 256;
    endcase
    return r;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_st = 0; m_mode = 0; m_v = 0; m_tick = 0; exp_stb = 0;
      exp_out = 0;
    end else begin
      exp_stb = 0;
      if (BTN_CLR) begin
        m_st = 0; m_v = m_start(m_mode); exp_stb = 1;
      end else if (BTN_RUN) begin
        if (m_st == 1) m_st = 2;
        else begin m_st = 1; m_tick = 0; end
      end else if (BTN_STEP && m_st != 1) begin
        m_v = m_adv(m_mode, m_v); m_st = 2; exp_stb = 1;
      end else if (BTN_MODE && m_st != 1) begin
        m_mode = (m_mode + 1) % 4; m_v = m_start(m_mode); exp_stb = 1;
      end else if (m_st == 1 && CE) begin
        if (m_tick == int'(RATE)) begin
          m_tick = 0; m_v = m_adv(m_mode, m_v); exp_stb = 1;
        end else m_tick = m_tick + 1;
      end
      if (exp_stb == 1) exp_out = (m_mode == 2) ? (m_v ^ (m_v / 2)) : m_v;
    end
    exp_mode = m_mode;
    exp_run  = (m_st == 1) ? 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (started && !RST) begin
      chk("cyc_seq_out", 32'(SEQ_OUT), 32'(exp_out));
      chk("cyc_seq_stb", 32'(SEQ_STB), 32'(exp_stb));
      chk("cyc_mode",    32'(MODE),    32'(exp_mode));
      chk("cyc_running", 32'(RUNNING), 32'(exp_run));
    end
  end

  task automatic press(input logic clr, input logic run, input logic step, input logic mode);
    @(negedge CLK);
    BTN_CLR = clr; BTN_RUN = run; BTN_STEP = step; BTN_MODE = mode;
    @(negedge CLK);
    BTN_CLR = 0; BTN_RUN = 0; BTN_STEP = 0; BTN_MODE = 0;
  endtask

  task automatic ce_tick();
    @(negedge CLK);
    CE = 1;
    @(negedge CLK);
    CE = 0;
  endtask

  logic [7:0] lfsr_exp [5];
  logic [7:0] gray_exp [4];

  initial begin
    lfsr_exp = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    gray_exp = '{8'h01, 8'h03, 8'h02, 8'h06};

    repeat (3) @(negedge CLK);
    RST = 0;
    started = 1;
    chk("rst_seq_out", 32'(SEQ_OUT), 32'h0);
    chk("rst_seq_stb", 32'(SEQ_STB), 32'h0);
    chk("rst_mode",    32'(MODE),    32'h0);
    chk("rst_running", 32'(RUNNING), 32'h0);

    // UP steps
    for (int i = 1; i <= 3; i++) begin
      press(0, 0, 1, 0);
      chk("up_step_out", 32'(SEQ_OUT), 32'(i));
      chk("up_step_stb", 32'(SEQ_STB), 32'h1);
    end
    @(negedge CLK);
    chk("up_stb_drop", 32'(SEQ_STB), 32'h0);
    chk("up_running",  32'(RUNNING), 32'h0);

    // DOWN, including wrap from 00
    press(0, 0, 0, 1);
    chk("down_load", 32'(SEQ_OUT), 32'hFF);
    chk("down_load_stb", 32'(SEQ_STB), 32'h1);
    press(0, 0, 1, 0);
    chk("down_step", 32'(SEQ_OUT), 32'hFE);
    for (int i = 0; i < 254; i++) press(0, 0, 1, 0);
    chk("down_zero", 32'(SEQ_OUT), 32'h00);
    press(0, 0, 1, 0);
    chk("down_wrap", 32'(SEQ_OUT), 32'hFF);

    // LFSR
    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    chk("lfsr_mode", 32'(MODE), 32'h3);
    chk("lfsr_load", 32'(SEQ_OUT), 32'h01);
    for (int i = 0; i < 5; i++) begin
      press(0, 0, 1, 0);
      chk("lfsr_step", 32'(SEQ_OUT), 32'(lfsr_exp[i]));
    end

    // GRAY
    press(0, 0, 0, 1);
    chk("up_reload", 32'(SEQ_OUT), 32'h00);
    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    chk("gray_mode", 32'(MODE), 32'h2);
    chk("gray_load", 32'(SEQ_OUT), 32'h00);
    for (int i = 0; i < 4; i++) begin
      press(0, 0, 1, 0);
      chk("gray_step", 32'(SEQ_OUT), 32'(gray_exp[i]));
    end

    // auto-step in RUN, UP mode, RATE=2
    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    chk("up_mode", 32'(MODE), 32'h0);
    RATE = 4'd2;
    press(0, 1, 0, 0);
    chk("run_running", 32'(RUNNING), 32'h1);
    chk("run_no_stb",  32'(SEQ_STB), 32'h0);
    for (int i = 1; i <= 9; i++) begin
      ce_tick();
      if (i % 3 == 0) begin
        chk("auto_out", 32'(SEQ_OUT), 32'(i / 3));
        chk("auto_stb", 32'(SEQ_STB), 32'h1);
      end else begin
        chk("auto_idle_stb", 32'(SEQ_STB), 32'h0);
      end
    end
    press(0, 0, 0, 1);
    chk("run_mode_ign", 32'(MODE), 32'h0);
    press(0, 0, 1, 0);
    chk("run_step_ign", 32'(SEQ_OUT), 32'h3);
    chk("run_step_stb", 32'(SEQ_STB), 32'h0);

    // simultaneous pulses
    press(1, 1, 0, 0);
    chk("clr_run_running", 32'(RUNNING), 32'h0);
    chk("clr_run_out", 32'(SEQ_OUT), 32'h0);
    chk("clr_run_stb", 32'(SEQ_STB), 32'h1);
    press(0, 0, 1, 0);
    chk("pause_step", 32'(SEQ_OUT), 32'h1);
    press(0, 1, 1, 0);
    chk("run_step_running", 32'(RUNNING), 32'h1);
    chk("run_step_out", 32'(SEQ_OUT), 32'h1);
    chk("run_step_nostb", 32'(SEQ_STB), 32'h0);

    // async reset mid-RUN at 0x2A
    RATE = 4'd0;
    for (int i = 0; i < 41; i++) ce_tick();
    chk("pre_rst_out", 32'(SEQ_OUT), 32'h2A);
    chk("pre_rst_stb", 32'(SEQ_STB), 32'h1);
    #2 RST = 1;
    #1;
    chk("async_out",  32'(SEQ_OUT), 32'h0);
    chk("async_mode", 32'(MODE),    32'h0);
    chk("async_run",  32'(RUNNING), 32'h0);
    chk("async_stb",  32'(SEQ_STB), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
    repeat (3) ce_tick();
    chk("idle_ce_out", 32'(SEQ_OUT), 32'h0);
    chk("idle_ce_run", 32'(RUNNING), 32'h0);
    press(0, 1, 0, 0);
    ce_tick();
    chk("rerun_out", 32'(SEQ_OUT), 32'h1);
    chk("rerun_stb", 32'(SEQ_STB), 32'h1);
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
